// File: rtl/fifo_byte_unpacker.sv
// Purpose: drains 32-bit words from a FIFO and serialises them MSB-first onto a byte valid/ready stream.
// Latency: fifo_rd in cycle N, FETCH in N+1, byte 0 valid in N+2; NBYTES+2 cycles per word with ready held high.
// Backpressure: byte_out/flags/index hold while valid && !ready; no new read is issued until the last byte is accepted.
//
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   fifo_empty, fifo_data  - FIFO status and registered read data (valid the cycle after fifo_rd)
//   fifo_rd                - combinational one-cycle read request, only from IDLE
//   byte_out/_valid/_ready - byte stream toward the sink
//   byte_first, byte_last  - byte 0 (MSB) / byte NBYTES-1 (LSB) markers
//   word_cnt               - words fully transmitted, wraps modulo 2^CNT_W
//   busy                   - high whenever the FSM is not in IDLE
module fifo_byte_unpacker #(
    parameter int WORD_W = 32,
    parameter int BYTE_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [WORD_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              byte_first,
    output logic              byte_last,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              busy
);

    // WORD_W is expected to be an integer multiple of BYTE_W.
    localparam int NBYTES = WORD_W / BYTE_W;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  word_q,  word_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        fifo_rd    = 1'b0;
        byte_valid = 1'b0;

        case (state_q)
            IDLE: begin
                // rst is folded in so the FIFO is never popped while the
                // block is held in reset.
                fifo_rd = !fifo_empty && !rst;
                if (fifo_rd) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                // Registered FIFO data lands this cycle.
                word_d  = fifo_data;
                idx_d   = '0;
                state_d = SEND;
            end

            SEND: begin
                byte_valid = 1'b1;
                if (byte_ready) begin
                    if (idx_q == LAST_IDX) begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = IDLE;
                    end else begin
                        // Next byte moves into the MSB slot that drives byte_out.
                        word_d = word_q << BYTE_W;
                        idx_d  = idx_q + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign byte_out   = word_q[WORD_W-1 -: BYTE_W];
    assign byte_first = (state_q == SEND) && (idx_q == '0);
    assign byte_last  = (state_q == SEND) && (idx_q == LAST_IDX);
    assign word_cnt   = cnt_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_byte_unpacker.sv
// Purpose: randomized and directed bench for fifo_byte_unpacker against a transaction-level byte scoreboard.
// Latency: outputs sampled on the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: byte_ready is driven per cycle by the bench; stalls are checked against the expected byte.
module tb_fifo_byte_unpacker;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int NBYTES = WORD_W / BYTE_W;
    localparam int WRAP_W = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                fifo_empty = 1'b1;
    logic [WORD_W-1:0]   fifo_data = '0;
    logic                byte_ready = 1'b0;

    logic                fifo_rd, byte_valid, byte_first, byte_last, busy;
    logic [BYTE_W-1:0]   byte_out;
    logic [15:0]         word_cnt;

    logic                w_fifo_rd, w_byte_valid, w_byte_first, w_byte_last, w_busy;
    logic [BYTE_W-1:0]   w_byte_out;
    logic [WRAP_W-1:0]   w_word_cnt;

    always #5 clk = ~clk;

    fifo_byte_unpacker u_dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_first (byte_first),
        .byte_last  (byte_last),
        .word_cnt   (word_cnt),
        .busy       (busy)
    );

    // Same stimulus, narrow counter: exercises the word_cnt wrap.
    fifo_byte_unpacker #(.CNT_W(WRAP_W)) u_wrap (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (w_fifo_rd),
        .byte_out   (w_byte_out),
        .byte_valid (w_byte_valid),
        .byte_ready (byte_ready),
        .byte_first (w_byte_first),
        .byte_last  (w_byte_last),
        .word_cnt   (w_word_cnt),
        .busy       (w_busy)
    );

    // FIFO contents and the byte stream those words must produce, in order.
    logic [WORD_W-1:0] fifo_q[$];
    logic [BYTE_W-1:0] exp_bytes[$];

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  pos = 0;          // bytes of the current word already accepted
    int  words_done = 0;
    int  have_word = 0;    // a word has been requested and is not finished
    int  rd_cyc = -10;
    int  rd_pending = 0;
    int  nrd = 0;
    int  end_cyc = -1;
    int  gap_en = 0;
    logic [BYTE_W-1:0] last_byte = '0;
    logic              last_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [WORD_W-1:0] w);
        fifo_q.push_back(w);
        for (int b = 0; b < NBYTES; b++) begin
            exp_bytes.push_back(w[WORD_W-1-BYTE_W*b -: BYTE_W]);
        end
    endtask

    // Discards the partially sent word and clears the model's counters.
    task automatic model_reset();
        if (have_word != 0) begin
            for (int b = pos; b < NBYTES; b++) begin
                if (exp_bytes.size() > 0) void'(exp_bytes.pop_front());
            end
        end
        pos        = 0;
        have_word  = 0;
        words_done = 0;
        rd_pending = 0;
        end_cyc    = -1;
    endtask

    // One clock cycle: check on the falling edge, then move the FIFO after the rising edge.
    task automatic step();
        logic exp_rd;
        logic exp_valid;
        fifo_empty = (fifo_q.size() == 0);
        @(negedge clk);
        cyc++;
        last_valid = byte_valid;
        last_byte  = byte_out;
        if (rst) begin
            chk("rst_outputs", {fifo_rd, byte_valid, byte_first, byte_last, busy}, 5'b0);
            chk("rst_byte_out", byte_out, 8'h00);
            chk("rst_word_cnt", word_cnt, 16'h0);
            chk("rst_wrap_cnt", w_word_cnt, 4'h0);
        end else begin
            exp_rd    = (have_word == 0) && (fifo_q.size() != 0);
            exp_valid = (have_word != 0) && (cyc >= rd_cyc + 2);
            chk("fifo_rd", fifo_rd, exp_rd);
            chk("busy", busy, have_word != 0);
            chk("byte_valid", byte_valid, exp_valid);
            chk("word_cnt", word_cnt, 32'(words_done % 65536));
            chk("wrap_ctl", {w_fifo_rd, w_busy, w_byte_valid}, {exp_rd, have_word != 0, exp_valid});
            chk("wrap_cnt", w_word_cnt, 32'(words_done % 16));
            if (exp_valid && exp_bytes.size() > 0) begin
                chk("byte_out", byte_out, exp_bytes[0]);
                chk("byte_first", byte_first, pos == 0);
                chk("byte_last", byte_last, pos == NBYTES - 1);
                chk("wrap_byte", {w_byte_out, w_byte_first, w_byte_last},
                    {exp_bytes[0], pos == 0, pos == NBYTES - 1});
                if (gap_en != 0 && pos == 0 && cyc == rd_cyc + 2 && end_cyc >= 0)
                    chk("word_gap", cyc - end_cyc, 3);
                if (byte_ready) begin
                    void'(exp_bytes.pop_front());
                    if (pos == NBYTES - 1) begin
                        pos        = 0;
                        words_done = words_done + 1;
                        have_word  = 0;
                        end_cyc    = cyc;
                    end else begin
                        pos = pos + 1;
                    end
                end
            end
            if (exp_rd) begin
                have_word = 1;
                rd_cyc    = cyc;
            end
            if (fifo_rd) begin
                rd_pending = 1;
                nrd        = nrd + 1;
            end
        end
        @(posedge clk);
        #1;
        if (rd_pending != 0 && fifo_q.size() > 0) begin
            fifo_data  = fifo_q.pop_front();
            rd_pending = 0;
        end
    endtask

    task automatic run_until_words(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && !(words_done >= target && have_word == 0); i++) begin
            step();
        end
        chk(tag, words_done, target);
    endtask

    initial begin
        int base_rd;

        // Reset with a word already waiting in the FIFO.
        #2 rst = 1'b1;
        push_word(32'hA1B2C3D4);
        repeat (3) step();
        rst        = 1'b0;
        byte_ready = 1'b1;
        step();
        chk("rd_after_rst", nrd, 1);

        // Single word.
        run_until_words(1, 20, "single_words");
        chk("single_cnt", word_cnt, 16'd1);
        chk("single_rd_pulses", nrd, 1);

        // Eight words back to back.
        gap_en  = 1;
        end_cyc = -1;
        for (int i = 0; i < 8; i++) push_word($urandom);
        run_until_words(9, 100, "b2b_words");
        repeat (4) step();
        chk("b2b_empty", fifo_empty, 1'b1);
        chk("b2b_rd_idle", fifo_rd, 1'b0);
        chk("b2b_rd_pulses", nrd, 9);
        gap_en = 0;

        // Three-cycle stall on the second byte.
        base_rd = nrd;
        push_word(32'h11223344);
        for (int i = 0; i < 10 && !(last_valid && last_byte == 8'h11); i++) step();
        byte_ready = 1'b0;
        repeat (3) step();
        chk("bp_hold_byte", last_byte, 8'h22);
        chk("bp_hold_valid", last_valid, 1'b1);
        byte_ready = 1'b1;
        run_until_words(10, 20, "bp_words");
        chk("bp_rd_pulses", nrd - base_rd, 1);

        // Reset after two bytes of a word are accepted.
        push_word(32'hDEADBEEF);
        push_word(32'h5A6B7C8D);
        for (int i = 0; i < 20 && !(have_word != 0 && pos == 2); i++) step();
        chk("mid_pos", pos, 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", byte_valid, 1'b0);
        chk("mid_rst_cnt", word_cnt, 16'h0);
        model_reset();
        repeat (2) step();
        rst = 1'b0;
        run_until_words(1, 20, "mid_restart_words");

        // Random traffic and random backpressure.
        for (int i = 0; i < 400; i++) begin
            if (fifo_q.size() < 8 && $urandom_range(2, 0) == 0) push_word($urandom);
            byte_ready = ($urandom_range(3, 0) != 0);
            step();
        end
        byte_ready = 1'b1;
        for (int i = 0; i < 100 && !(fifo_q.size() == 0 && have_word == 0); i++) step();
        chk("rand_drained", exp_bytes.size(), 0);

        // Counter wrap: 17 words from reset.
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
        for (int i = 0, pushed = 0; i < 400 && words_done < 17; i++) begin
            if (pushed < 17 && fifo_q.size() < 8) begin
                push_word($urandom);
                pushed++;
            end
            step();
        end
        repeat (3) step();
        chk("wrap_words", words_done, 17);
        chk("wrap_final_cnt", w_word_cnt, 4'd1);
        chk("wide_final_cnt", word_cnt, 16'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
